multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

- Multi-cycle control unit for the single-issue CPU.
- Runs one finite-state machine that steps each instruction through IF/ID/EXE/MEM/WB and drives the datapath enables.
- Its PCWre and PCSrc outputs feed the program-counter register directly: the PC advances only on the last cycle of each instruction.
- Also keeps a retired-instruction counter for debug and bring-up.

## Interface
- CNT_W, 16, width of retired-instruction counter
- CLK  in  1  clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low; 0 forces IF state and clears counter
- opcode  in  6  IR[31:26]; latched into op_q at end of ID
- Zero  in  1  ALU zero flag; sampled only in EXE_BR
- PCWre  out  1  PC write enable
- PCSrc  out  1  0: PC+4, 1: PC+4+(imm<<2)
- IRWre  out  1  instruction-register load
- ALUSrcB  out  1  0: rt data, 1: extended immediate
- ALUOp  out  3  000 add, 001 sub, 011 or, 100 and
- ExtSel  out  1  1 sign-extend, 0 zero-extend
- RegDst  out  1  1: rd, 0: rt
- RegWre  out  1  register-file write enable
- DBDataSrc  out  1  0: ALU result, 1: data memory
- mRD, mWR  out  1 each  data-memory read/write strobes
- state  out  4  current state code, for debug
- InsCount  out  CNT_W  retired-instruction count, wraps

## Operation
- Opcodes:
  - add 000000, sub 000001, and 010001, or 010000: R-type
  - addi 000010, ori 010010
  - sw 110000, lw 110001, beq 110100
  - halt 111111
  - any other opcode is illegal.
- State codes: IF 0000, ID 0001, EXE_LS 0010, MEM 0011, WB_LD 0100, EXE_BR 0101, EXE_AL 0110, WB_AL 0111, HALT 1000.
- Transitions:
  - IF→ID.
  - ID: R-type/addi/ori→EXE_AL; beq→EXE_BR; lw/sw→EXE_LS; halt→HALT (see Configuration); illegal→IF.
  - EXE_AL→WB_AL→IF.
  - EXE_BR→IF.
  - EXE_LS→MEM.
  - MEM: lw→WB_LD, sw→IF.
  - WB_LD→IF.
  - HALT→HALT until reset.
- Outputs are decoded combinationally from state and op_q (opcode when in ID). Any signal not listed below is 0.
  - IF: IRWre=1.
  - ID: PCWre=1 only for an illegal opcode (treated as nop).
  - EXE_AL: ALUSrcB=1 for addi/ori. ALUOp per opcode (addi→000, ori→011). ExtSel=1 for addi, 0 for ori.
  - EXE_BR: ALUOp=001, ExtSel=1, PCWre=1, PCSrc=Zero.
  - EXE_LS: ALUSrcB=1, ALUOp=000, ExtSel=1.
  - MEM: lw gives mRD=1. sw gives mWR=1, PCWre=1.
  - WB_AL: RegWre=1, PCWre=1, RegDst=1 for R-type.
  - WB_LD: RegWre=1, DBDataSrc=1, PCWre=1, RegDst=0.
- EXE-state ALU controls (ALUSrcB, ALUOp, ExtSel) are held through MEM/WB so the ALU result stays stable.
- InsCount increments by 1 on every rising edge where PCWre=1. It wraps from all-ones to 0.

## Timing
- While Reset=0: state=IF, op_q=0, InsCount=0, every control output forced to 0 (including IRWre).
- First IRWre pulse is in the first cycle after Reset rises.
- Reset falling mid-instruction aborts it immediately. No PCWre, RegWre or mWR is issued after the falling edge.
- Latency in cycles, IF to PC update inclusive:
  - illegal opcode: 2
  - beq: 3
  - R-type/addi/ori: 4
  - sw: 4
  - lw: 5
- PCWre is high for exactly one cycle per retired instruction: the final cycle. The PC updates on that cycle's closing edge.
- PCSrc is valid only while PCWre=1. Zero must settle within the EXE_BR cycle.
- mWR is a single-cycle strobe; the memory captures on the MEM closing edge.
- opcode may change after ID; op_q holds the decode for the rest of the instruction.

## Configuration
- Macro: MULTI_CYCLE_CTRL_HALT_EN.
- Defined: opcode 111111 enters HALT. HALT is permanent until Reset.
  - PCWre=0 and all strobes are 0 while halted.
  - InsCount stops.
  - state reads 1000.
- Undefined: HALT state is not built. 111111 is illegal: 2-cycle nop, PC advances, InsCount increments.

## Test plan
- Reset=0 mid-WB_LD, then release → outputs 0 during reset; IF with IRWre=1 next cycle; InsCount=0.
- add 000000 from IF → states 0000,0001,0110,0111,0000. RegWre=1, RegDst=1, PCWre=1 only in WB_AL. InsCount=1.
- beq with Zero=1, then beq with Zero=0 → EXE_BR gives PCWre=1 with PCSrc=1, then PCWre=1 with PCSrc=0. 3 cycles each.
- lw then sw → lw: mRD=1 in MEM, DBDataSrc=1 and RegWre=1 in WB_LD (5 cycles). sw: mWR=1 and PCWre=1 in MEM (4 cycles).
- opcode 101010 → ID gives PCWre=1, back to IF, InsCount+1. Opcode 111111 → state 1000 held 20 cycles, PCWre=0 (macro defined); nop otherwise.
- Preload InsCount to 0xFFFF via 65535 retirements plus one more → InsCount=0x0000.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB control FSM with retired-instruction counter.
// Optional HALT state is built when MULTI_CYCLE_CTRL_HALT_EN is defined.
module multi_cycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       opcode,
    input  logic             Zero,
    output logic             PCWre,
    output logic             PCSrc,
    output logic             IRWre,
    output logic             ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             ExtSel,
    output logic             RegDst,
    output logic             RegWre,
    output logic             DBDataSrc,
    output logic             mRD,
    output logic             mWR,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] InsCount
);

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_LD  = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    state_t     st;
    state_t     nxt;
    logic [5:0] op_q;
    logic [5:0] op;

    logic is_add, is_sub, is_and, is_or;
    logic is_addi, is_ori, is_sw, is_lw, is_beq, is_halt;
    logic is_r, is_al, legal;

    logic       al_b;
    logic [2:0] al_op;
    logic       al_ext;

    // In ID the opcode is still on the bus; later states use the latched copy.
    assign op = (st == S_ID) ? opcode : op_q;

    assign is_add  = (op == 6'b000000);
    assign is_sub  = (op == 6'b000001);
    assign is_and  = (op == 6'b010001);
    assign is_or   = (op == 6'b010000);
    assign is_addi = (op == 6'b000010);
    assign is_ori  = (op == 6'b010010);
    assign is_sw   = (op == 6'b110000);
    assign is_lw   = (op == 6'b110001);
    assign is_beq  = (op == 6'b110100);
`ifdef MULTI_CYCLE_CTRL_HALT_EN
    assign is_halt = (op == 6'b111111);
`else
    assign is_halt = 1'b0;
`endif

    assign is_r  = is_add | is_sub | is_and | is_or;
    assign is_al = is_r | is_addi | is_ori;
    assign legal = is_al | is_sw | is_lw | is_beq | is_halt;

    always_comb begin
        al_b   = is_addi | is_ori;
        al_ext = is_addi;
        al_op  = 3'b000;
        if (is_sub)              al_op = 3'b001;
        else if (is_or | is_ori) al_op = 3'b011;
        else if (is_and)         al_op = 3'b100;
    end

    always_comb begin
        nxt = S_IF;
        unique case (st)
            S_IF: nxt = S_ID;
            S_ID: begin
                if (is_al)              nxt = S_EXE_AL;
                else if (is_beq)        nxt = S_EXE_BR;
                else if (is_lw | is_sw) nxt = S_EXE_LS;
`ifdef MULTI_CYCLE_CTRL_HALT_EN
                else if (is_halt)       nxt = S_HALT;
`endif
                else                    nxt = S_IF;
            end
            S_EXE_AL: nxt = S_WB_AL;
            S_WB_AL:  nxt = S_IF;
            S_EXE_BR: nxt = S_IF;
            S_EXE_LS: nxt = S_MEM;
            S_MEM:    nxt = is_lw ? S_WB_LD : S_IF;
            S_WB_LD:  nxt = S_IF;
`ifdef MULTI_CYCLE_CTRL_HALT_EN
            S_HALT:   nxt = S_HALT;
`endif
            default:  nxt = S_IF;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            st       <= S_IF;
            op_q     <= 6'b000000;
            InsCount <= '0;
        end else begin
            st <= nxt;
            if (st == S_ID) op_q <= opcode;
            if (PCWre) InsCount <= InsCount + CNT_W'(1);
        end
    end

    assign state = st;

    // Everything is gated by Reset so an abort takes effect on the falling edge.
    always_comb begin
        PCWre     = 1'b0;
        PCSrc     = 1'b0;
        IRWre     = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = 3'b000;
        ExtSel    = 1'b0;
        RegDst    = 1'b0;
        RegWre    = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        if (Reset) begin
            unique case (st)
                S_IF: IRWre = 1'b1;
                S_ID: PCWre = ~legal;
                S_EXE_AL: begin
                    ALUSrcB = al_b;
                    ALUOp   = al_op;
                    ExtSel  = al_ext;
                end
                S_WB_AL: begin
                    ALUSrcB = al_b;
                    ALUOp   = al_op;
                    ExtSel  = al_ext;
                    RegWre  = 1'b1;
                    PCWre   = 1'b1;
                    RegDst  = is_r;
                end
                S_EXE_BR: begin
                    ALUOp  = 3'b001;
                    ExtSel = 1'b1;
                    PCWre  = 1'b1;
                    PCSrc  = Zero;
                end
                S_EXE_LS: begin
                    ALUSrcB = 1'b1;
                    ExtSel  = 1'b1;
                end
                S_MEM: begin
                    ALUSrcB = 1'b1;
                    ExtSel  = 1'b1;
                    mRD     = is_lw;
                    mWR     = is_sw;
                    PCWre   = is_sw;
                end
                S_WB_LD: begin
                    ALUSrcB   = 1'b1;
                    ExtSel    = 1'b1;
                    RegWre    = 1'b1;
                    DBDataSrc = 1'b1;
                    PCWre     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized bench for multi_cycle_ctrl against a per-instruction model.
// Honours MULTI_CYCLE_CTRL_HALT_EN the same way as the design.
module tb_multi_cycle_ctrl;

    localparam int CW = 8;

    localparam int C_ILL  = 0;
    localparam int C_BR   = 1;
    localparam int C_ALU  = 2;
    localparam int C_SW   = 3;
    localparam int C_LW   = 4;
    localparam int C_HALT = 5;

    logic          CLK;
    logic          Reset;
    logic [5:0]    opcode;
    logic          Zero;
    logic          PCWre, PCSrc, IRWre, ALUSrcB, ExtSel;
    logic          RegDst, RegWre, DBDataSrc, mRD, mWR;
    logic [2:0]    ALUOp;
    logic [3:0]    state;
    logic [CW-1:0] InsCount;

    int            n_tests;
    int            n_fail;
    logic [CW-1:0] cnt;

    multi_cycle_ctrl #(.CNT_W(CW)) dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .Zero(Zero),
        .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
        .RegDst(RegDst), .RegWre(RegWre), .DBDataSrc(DBDataSrc),
        .mRD(mRD), .mWR(mWR), .state(state), .InsCount(InsCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cls(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b010001,
            6'b010000, 6'b000010, 6'b010010: return C_ALU;
            6'b110100: return C_BR;
            6'b110000: return C_SW;
            6'b110001: return C_LW;
`ifdef MULTI_CYCLE_CTRL_HALT_EN
            6'b111111: return C_HALT;
`endif
            default:   return C_ILL;
        endcase
    endfunction

    function automatic int lat(input int c);
        case (c)
            C_BR:    return 3;
            C_ALU:   return 4;
            C_SW:    return 4;
            C_LW:    return 5;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] trace_of(input int c);
        case (c)
            C_BR:    return 32'h015;
            C_ALU:   return 32'h0167;
            C_SW:    return 32'h0123;
            C_LW:    return 32'h01234;
            default: return 32'h01;
        endcase
    endfunction

    // {ALUSrcB, ALUOp, ExtSel} expected on the retiring cycle
    function automatic logic [4:0] alu_of(input logic [5:0] op);
        case (op)
            6'b000000: return 5'b0_000_0;
            6'b000001: return 5'b0_001_0;
            6'b010001: return 5'b0_100_0;
            6'b010000: return 5'b0_011_0;
            6'b000010: return 5'b1_000_1;
            6'b010010: return 5'b1_011_0;
            6'b110000: return 5'b1_000_1;
            6'b110001: return 5'b1_000_1;
            6'b110100: return 5'b0_001_1;
            default:   return 5'b0_000_0;
        endcase
    endfunction

    function automatic logic [12:0] all_out();
        return {PCWre, PCSrc, IRWre, ALUSrcB, ALUOp, ExtSel,
                RegDst, RegWre, DBDataSrc, mRD, mWR};
    endfunction

    // Entered at posedge+1 with the DUT in IF.
    task automatic run_instr(input logic [5:0] op, input logic z);
        int          c;
        int          k;
        bit          done;
        logic [31:0] tr;
        int          nir, nrw, nrd, nwr, ndb;
        logic        rdst;
        logic [4:0]  alu_last;
        logic        src_last;
        c = cls(op);
        k = 0; done = 0; tr = 0;
        nir = 0; nrw = 0; nrd = 0; nwr = 0; ndb = 0;
        rdst = 0; alu_last = 0; src_last = 0;
        while (!done && k < 8) begin
            opcode = (k < 2) ? op : 6'($urandom);
            Zero   = (k == 2) ? z : 1'($urandom);
            #1;
            tr = {tr[27:0], state};
            nir += int'(IRWre);
            nrd += int'(mRD);
            nwr += int'(mWR);
            ndb += int'(DBDataSrc);
            if (RegWre) begin
                nrw++;
                rdst = RegDst;
            end
            if (PCWre) begin
                done     = 1;
                alu_last = {ALUSrcB, ALUOp, ExtSel};
                src_last = PCSrc;
            end
            @(posedge CLK);
            #1;
            k++;
        end
        if (done) cnt = cnt + CW'(1);
        check("retired", 32'(done), 32'd1);
        check("latency", k, lat(c));
        check("trace", tr, trace_of(c));
        check("irwre_n", nir, 1);
        check("regwre_n", nrw, (c == C_ALU || c == C_LW) ? 1 : 0);
        check("regdst", 32'(rdst), 32'(c == C_ALU && op[1] == 1'b0));
        check("mrd_n", nrd, (c == C_LW) ? 1 : 0);
        check("mwr_n", nwr, (c == C_SW) ? 1 : 0);
        check("dbsrc_n", ndb, (c == C_LW) ? 1 : 0);
        check("alu_ctl", 32'(alu_last), 32'(alu_of(op)));
        check("pcsrc", 32'(src_last), 32'(c == C_BR && z));
        check("inscount", 32'(InsCount), 32'(cnt));
    endtask

    logic [5:0] ops [10];
    logic [5:0] rop;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cnt     = '0;
        ops = '{6'b000000, 6'b000001, 6'b010001, 6'b010000, 6'b000010,
                6'b010010, 6'b110000, 6'b110001, 6'b110100, 6'b101010};
        Reset  = 1'b0;
        opcode = 6'b000000;
        Zero   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out", 32'(all_out()), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_cnt", 32'(InsCount), 32'd0);
        Reset = 1'b1;
        #1;
        check("first_irwre", 32'(IRWre), 32'd1);

        run_instr(6'b000000, 1'b0);
        run_instr(6'b110100, 1'b1);
        run_instr(6'b110100, 1'b0);
        run_instr(6'b110001, 1'b0);
        run_instr(6'b110000, 1'b0);
        run_instr(6'b101010, 1'b0);

        // Abort a load in WB_LD.
        opcode = 6'b110001;
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        check("pre_abort", 32'(state), 32'h4);
        #2;
        Reset = 1'b0;
        #1;
        check("abort_out", 32'(all_out()), 32'd0);
        check("abort_state", 32'(state), 32'd0);
        check("abort_cnt", 32'(InsCount), 32'd0);
        @(posedge CLK);
        #1;
        check("hold_out", 32'(all_out()), 32'd0);
        Reset = 1'b1;
        cnt   = '0;
        #1;
        check("rel_irwre", 32'(IRWre), 32'd1);
        check("rel_state", 32'(state), 32'd0);
        check("rel_cnt", 32'(InsCount), 32'd0);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 7) rop = ops[$urandom_range(0, 9)];
            else begin
                rop = 6'($urandom);
                if (rop == 6'b111111) rop = 6'b101010;
            end
            run_instr(rop, 1'($urandom));
        end

        while (cnt != '1) run_instr(6'b101010, 1'b0);
        check("cnt_full", 32'(InsCount), 32'hFF);
        run_instr(6'b011011, 1'b0);
        check("cnt_wrap", 32'(InsCount), 32'h0);

`ifdef MULTI_CYCLE_CTRL_HALT_EN
        opcode = 6'b111111;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        for (int i = 0; i < 20; i++) begin
            opcode = 6'($urandom);
            #1;
            check("halt_state", 32'(state), 32'h8);
            check("halt_out", 32'(all_out()), 32'd0);
            check("halt_cnt", 32'(InsCount), 32'(cnt));
            @(posedge CLK);
            #1;
        end
`else
        run_instr(6'b111111, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
